// File: rtl/radio_pkg.sv
// Shared types and constants for the radio transceiver.
package radio_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX_START,
      S_TX_DATA,
      S_TX_STOP,
      S_RX_WAIT,
      S_RX_START,
      S_RX_DATA,
      S_RX_STOP
   } radio_state_e;

   localparam logic RF_IDLE_LEVEL = 1'b1;
   localparam int   FRAME_BITS    = 10;

endpackage

// File: rtl/radio_bit_timer.sv
// Baud counter shared by the TX and RX paths; strobes mid-bit and end-of-bit.
module radio_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart_i,
   output logic mid_o,
   output logic end_o
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign mid_o = (cnt_q == MID);
   assign end_o = (cnt_q == LAST);

endmodule

// File: rtl/radio_transceiver.sv
// Half-duplex UART-style radio responder: serialises a controller byte onto rf_tx
// or deserialises one rf_rx frame back onto the shared radio_data bus.
module radio_transceiver
   import radio_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int RX_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       radio_enable,
   input  logic       radio_send,
   input  logic       radio_receive,
   inout  wire  [7:0] radio_data,
   output logic       radio_busy,
   output logic       rf_tx,
   input  logic       rf_rx,
   output logic       rx_valid,
   output logic       rx_error,
   output logic       rx_timeout
);

   localparam int            TW       = $clog2(RX_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(RX_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(RX_TIMEOUT);

   radio_state_e  state_q, state_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic [2:0]    bit_q, bit_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          rf_tx_q, rf_tx_d;
   logic          data_oe_q, data_oe_d;
   logic          rx_valid_q, rx_valid_d;
   logic          rx_error_q, rx_error_d;
   logic          rx_timeout_q, rx_timeout_d;
   logic [1:0]    sync_q;
   logic          rx_s, restart, bit_mid, bit_end;

   assign rx_s = sync_q[1];

   radio_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart_i (restart),
      .mid_o     (bit_mid),
      .end_o     (bit_end)
   );

   always_comb begin
      state_d      = state_q;
      tx_shift_d   = tx_shift_q;
      rx_shift_d   = rx_shift_q;
      rx_byte_d    = rx_byte_q;
      bit_d        = bit_q;
      tmo_d        = tmo_q;
      rf_tx_d      = rf_tx_q;
      data_oe_d    = data_oe_q;
      rx_valid_d   = 1'b0;
      rx_error_d   = 1'b0;
      rx_timeout_d = 1'b0;
      restart      = 1'b0;
      if (!radio_enable) begin
         state_d   = S_IDLE;
         rf_tx_d   = RF_IDLE_LEVEL;
         data_oe_d = 1'b0;
         bit_d     = '0;
         tmo_d     = '0;
         restart   = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               restart = 1'b1;
               bit_d   = '0;
               tmo_d   = '0;
               rf_tx_d = RF_IDLE_LEVEL;
               if (radio_send) begin
                  tx_shift_d = radio_data;
                  data_oe_d  = 1'b0;
                  rf_tx_d    = 1'b0;
                  state_d    = S_TX_START;
               end else if (radio_receive) begin
                  data_oe_d = 1'b0;
                  state_d   = S_RX_WAIT;
               end
            end
            S_TX_START: if (bit_end) begin
               rf_tx_d    = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
               state_d    = S_TX_DATA;
            end
            S_TX_DATA: if (bit_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  rf_tx_d = RF_IDLE_LEVEL;
                  state_d = S_TX_STOP;
               end else begin
                  rf_tx_d    = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
            S_TX_STOP: if (bit_end) state_d = S_IDLE;
            // Timer held in restart so RX_START begins its half-bit count from zero
            S_RX_WAIT: begin
               restart = 1'b1;
               if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
               if (!rx_s) begin
                  state_d = S_RX_START;
               end else if (tmo_q >= TMO_LAST) begin
                  rx_timeout_d = 1'b1;
                  state_d      = S_IDLE;
               end
            end
            S_RX_START: begin
               if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
               if (bit_mid) begin
                  restart = 1'b1;
                  state_d = rx_s ? S_RX_WAIT : S_RX_DATA;
               end
            end
            S_RX_DATA: if (bit_end) begin
               rx_shift_d = {rx_s, rx_shift_q[7:1]};
               bit_d      = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = S_RX_STOP;
            end
            S_RX_STOP: if (bit_end) begin
               state_d = S_IDLE;
               if (rx_s) begin
                  rx_byte_d  = rx_shift_q;
                  data_oe_d  = 1'b1;
                  rx_valid_d = 1'b1;
               end else begin
                  rx_error_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tx_shift_q   <= '0;
         rx_shift_q   <= '0;
         rx_byte_q    <= '0;
         bit_q        <= '0;
         tmo_q        <= '0;
         rf_tx_q      <= RF_IDLE_LEVEL;
         data_oe_q    <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_error_q   <= 1'b0;
         rx_timeout_q <= 1'b0;
         sync_q       <= 2'b11;
      end else begin
         state_q      <= state_d;
         tx_shift_q   <= tx_shift_d;
         rx_shift_q   <= rx_shift_d;
         rx_byte_q    <= rx_byte_d;
         bit_q        <= bit_d;
         tmo_q        <= tmo_d;
         rf_tx_q      <= rf_tx_d;
         data_oe_q    <= data_oe_d;
         rx_valid_q   <= rx_valid_d;
         rx_error_q   <= rx_error_d;
         rx_timeout_q <= rx_timeout_d;
         sync_q       <= {sync_q[0], rf_rx};
      end
   end

   assign radio_data = data_oe_q ? rx_byte_q : 8'bz;
   assign radio_busy = (state_q != S_IDLE);
   assign rf_tx      = rf_tx_q;
   assign rx_valid   = rx_valid_q;
   assign rx_error   = rx_error_q;
   assign rx_timeout = rx_timeout_q;

endmodule

// File: tb/tb_radio_transceiver.sv
// Scoreboard bench: stimulus queues expected radio events, a monitor checks them.
module tb_radio_transceiver;
   import radio_pkg::*;

   localparam int CPB  = 4;
   localparam int TMO  = 64;
   localparam int FLEN = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       radio_enable = 1'b0;
   logic       radio_send = 1'b0;
   logic       radio_receive = 1'b0;
   logic       rf_rx = 1'b1;
   logic [7:0] tb_drv = 8'h00;
   logic       tb_oe = 1'b0;
   wire  [7:0] radio_data;
   logic       radio_busy, rf_tx, rx_valid, rx_error, rx_timeout;

   assign radio_data = tb_oe ? tb_drv : 8'bz;
   always #5 clk = ~clk;

   radio_transceiver #(.CLKS_PER_BIT(CPB), .RX_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .radio_enable  (radio_enable),
      .radio_send    (radio_send),
      .radio_receive (radio_receive),
      .radio_data    (radio_data),
      .radio_busy    (radio_busy),
      .rf_tx         (rf_tx),
      .rf_rx         (rf_rx),
      .rx_valid      (rx_valid),
      .rx_error      (rx_error),
      .rx_timeout    (rx_timeout)
   );

   typedef enum logic [2:0] {EV_NONE, EV_TX, EV_RXV, EV_RXE, EV_TMO} ev_kind_e;
   typedef struct packed {
      ev_kind_e   kind;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   bit         mon_on = 1'b0;
   bit         model_oe = 1'b0;
   logic [7:0] model_rx = 8'h00;
   logic [FLEN-1:0] mon_wave, mon_exp;
   logic [9:0]      mon_frame;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pop_chk(input ev_kind_e k, input logic [7:0] d, output ev_t e);
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d, nothing expected", k);
         e = '{kind: EV_NONE, data: 8'h00};
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", longint'(k), longint'(e.kind));
         if (k == EV_RXV) chk("rx_byte", longint'(d), longint'(e.data));
      end
   endtask

   // Monitor: status pulses and whole rf_tx frames against the expected queue
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_on && rst_n) begin
            if (rx_valid)   pop_chk(EV_RXV, radio_data, e);
            if (rx_error)   pop_chk(EV_RXE, 8'h00, e);
            if (rx_timeout) pop_chk(EV_TMO, 8'h00, e);
            if (!rf_tx) begin
               mon_wave[0] = rf_tx;
               for (int i = 1; i < FLEN; i++) begin
                  @(negedge clk);
                  mon_wave[i] = rf_tx;
               end
               pop_chk(EV_TX, 8'h00, e);
               if (e.kind == EV_TX) begin
                  mon_frame = {1'b1, e.data, 1'b0};
                  for (int i = 0; i < FLEN; i++) mon_exp[i] = mon_frame[i / CPB];
                  chk("tx_frame", longint'(mon_wave), longint'(mon_exp));
               end
            end
         end
      end
   end

   task automatic check_data_bus();
      if (model_oe) begin
         #1;
         chk("rx_data_hold", longint'(radio_data), longint'(model_rx));
      end else begin
         tb_drv = 8'($urandom);
         tb_oe  = 1'b1;
         #1;
         chk("data_bus_released", longint'(radio_data), longint'(tb_drv));
         tb_oe  = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic release_bus();
      if (model_oe) begin
         radio_enable = 1'b0;
         @(negedge clk);
         radio_enable = 1'b1;
         model_oe     = 1'b0;
         tb_drv = 8'($urandom);
         tb_oe  = 1'b1;
         #1;
         chk("enable_low_releases_bus", longint'(radio_data), longint'(tb_drv));
         tb_oe  = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_tx(input logic [7:0] b, input bit both, input bit stray);
      int cnt;
      release_bus();
      tb_drv = b;
      tb_oe  = 1'b1;
      radio_send    = 1'b1;
      radio_receive = both;
      exp_q.push_back('{kind: EV_TX, data: b});
      @(negedge clk);
      radio_send    = 1'b0;
      radio_receive = 1'b0;
      tb_oe         = 1'b0;
      cnt = 0;
      while (radio_busy && cnt < 200) begin
         cnt++;
         if (stray && cnt == 10) begin
            tb_drv     = ~b;
            tb_oe      = 1'b1;
            radio_send = 1'b1;
         end
         @(negedge clk);
         radio_send = 1'b0;
         tb_oe      = 1'b0;
      end
      chk("tx_busy_cycles", longint'(cnt), longint'(FLEN));
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rf_rx = f[i];
         repeat (CPB) @(negedge clk);
      end
      rf_rx = 1'b1;
   endtask

   task automatic do_rx(input logic [7:0] b, input bit stop, input bit glitch);
      int cnt;
      radio_receive = 1'b1;
      @(negedge clk);
      radio_receive = 1'b0;
      model_oe      = 1'b0;
      repeat ($urandom_range(2, 10)) @(negedge clk);
      if (glitch) begin
         rf_rx = 1'b0;
         repeat (2) @(negedge clk);
         rf_rx = 1'b1;
         repeat (6) @(negedge clk);
      end
      if (stop) exp_q.push_back('{kind: EV_RXV, data: b});
      else      exp_q.push_back('{kind: EV_RXE, data: 8'h00});
      send_frame(b, stop);
      cnt = 0;
      while (radio_busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("rx_returns_idle", longint'(radio_busy), 0);
      if (stop) begin
         model_oe = 1'b1;
         model_rx = b;
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
      check_data_bus();
   endtask

   task automatic do_timeout();
      int cnt;
      radio_receive = 1'b1;
      @(negedge clk);
      radio_receive = 1'b0;
      model_oe      = 1'b0;
      exp_q.push_back('{kind: EV_TMO, data: 8'h00});
      cnt = 0;
      while (radio_busy && cnt < 4 * TMO) begin
         cnt++;
         @(negedge clk);
      end
      chk("rx_timeout_latency", longint'(cnt), longint'(TMO));
      chk("rx_timeout_pulse", longint'(rx_timeout), 1);
      @(negedge clk);
      check_data_bus();
   endtask

   task automatic abort_tx();
      mon_on = 1'b0;
      release_bus();
      tb_drv = 8'h00;
      tb_oe  = 1'b1;
      radio_send = 1'b1;
      @(negedge clk);
      radio_send = 1'b0;
      tb_oe      = 1'b0;
      repeat (2 * CPB + 3) @(negedge clk);
      chk("tx_active_before_abort", longint'(rf_tx), 0);
      radio_enable = 1'b0;
      @(negedge clk);
      chk("abort_rf_tx", longint'(rf_tx), 1);
      chk("abort_busy", longint'(radio_busy), 0);
      chk("abort_no_pulse", longint'({rx_valid, rx_error, rx_timeout}), 0);
      radio_enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", longint'({radio_busy, rf_tx}), 1);
      mon_on = 1'b1;
   endtask

   task automatic reset_tests();
      mon_on = 1'b0;
      if (model_oe) begin
         rst_n = 1'b0;
         tb_drv = ~model_rx;
         tb_oe  = 1'b1;
         #1;
         chk("reset_releases_bus", longint'(radio_data), longint'(tb_drv));
         tb_oe = 1'b0;
         @(negedge clk);
         rst_n    = 1'b1;
         model_oe = 1'b0;
         repeat (3) @(negedge clk);
      end
      radio_receive = 1'b1;
      @(negedge clk);
      radio_receive = 1'b0;
      repeat (3) @(negedge clk);
      rf_rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      chk("rx_busy_before_reset", longint'(radio_busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrx_reset_busy", longint'(radio_busy), 0);
      chk("midrx_reset_rf_tx", longint'(rf_tx), 1);
      chk("midrx_reset_pulses", longint'({rx_valid, rx_error, rx_timeout}), 0);
      rf_rx = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_idle", longint'(radio_busy), 0);
      mon_on = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      chk("reset_busy", longint'(radio_busy), 0);
      chk("reset_rf_tx", longint'(rf_tx), 1);
      chk("reset_pulses", longint'({rx_valid, rx_error, rx_timeout}), 0);
      rst_n        = 1'b1;
      radio_enable = 1'b1;
      mon_on       = 1'b1;
      repeat (4) @(negedge clk);

      do_tx(8'hA5, 1'b0, 1'b0);
      do_rx(8'h3C, 1'b1, 1'b0);
      do_rx(8'hFF, 1'b0, 1'b0);
      do_timeout();
      do_tx(8'h96, 1'b1, 1'b1);
      do_rx(8'h5B, 1'b1, 1'b1);
      abort_tx();
      do_rx(8'hE7, 1'b1, 1'b0);
      reset_tests();

      for (int n = 0; n < 40; n++) begin
         k = int'($urandom_range(0, 9));
         if (k < 4)
            do_tx(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (k < 9)
            do_rx(8'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
         else
            do_timeout();
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", longint'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
